inst_dy_byte_ser: RTL and testbench

//  Downstream of the DY instruct-slice stage. Accepts one registered 128-bit DY instruct word per
//  dy_tx_data_valid pulse and serialises it, MSB byte first, into a valid/ready byte stream toward
//  the DY interface. Adds frame markers, busy/drop status and a frame counter; enforces an idle gap.

---
 rtl/inst_dy_pkg.sv | 28 ++
 rtl/inst_dy_byte_ser.sv | 197 +++++++++++++++++++
 tb/tb_inst_dy_byte_ser.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_dy_pkg.sv
// -----------------------------------------------------------------------------
// inst_dy_pkg
// Shared definitions for the DY instruct byte serialiser: FSM state encoding,
// word/byte geometry and the effective-length helper.
// -----------------------------------------------------------------------------
package inst_dy_pkg;

  localparam int DY_WORD_BYTES = 16;
  localparam int DY_BYTE_W     = 8;
  localparam int DY_WORD_W     = DY_WORD_BYTES * DY_BYTE_W;
  localparam int DY_IDX_W      = 4;   // byte index 0..15
  localparam int DY_LEN_W      = 5;   // effective length 0..16
  localparam int DY_GAP_W      = 8;   // idle gap counter 0..255

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CSUM = 2'd2,
    ST_GAP  = 2'd3
  } dy_state_t;

  // Lengths beyond one word are clipped to the word size.
  function automatic logic [DY_LEN_W-1:0] dy_len_eff(input logic [15:0] cfg_len);
    if (cfg_len > 16'(DY_WORD_BYTES)) return DY_LEN_W'(DY_WORD_BYTES);
    else                              return cfg_len[DY_LEN_W-1:0];
  endfunction

endpackage

// File: rtl/inst_dy_byte_ser.sv
// -----------------------------------------------------------------------------
// inst_dy_byte_ser
// Serialises one 128-bit DY instruct word per dy_tx_data_valid strobe into a
// valid/ready byte stream, MSB byte first, with sof/eof markers, busy/drop
// status, a completed-frame counter and a minimum idle gap between frames.
//
// Configuration macro: DY_TX_CHECKSUM_EN
//   defined   : one extra byte (sum mod 256 of the data bytes) closes each
//               frame and carries eof.
//   undefined : eof sits on the last data byte.
//
// Parameters
//   U_DLY     simulation delay for assignments; not modelled in this RTL,
//             kept so existing instantiations still bind.
//   IDLE_GAP  idle cycles after the last byte handshake before a new word
//             can be accepted (0..255).
//
// Ports
//   clk_sys           in   system clock
//   rst               in   asynchronous active-high reset
//   cfg_ins_length    in   instruct length in bytes, sampled at accept
//   dy_tx_data        in   instruct word, byte0 = [127:120]
//   dy_tx_data_valid  in   1-cycle word strobe
//   dy_byte_ready     in   sink ready
//   dy_byte_data      out  byte to DY
//   dy_byte_valid     out  byte valid, held until ready
//   dy_byte_sof       out  first byte of frame
//   dy_byte_eof       out  last byte of frame
//   dy_tx_busy        out  high from accept through end of gap
//   dy_tx_drop        out  1-cycle pulse: strobe ignored
//   dy_frame_cnt      out  completed frames, wrapping
// -----------------------------------------------------------------------------
module inst_dy_byte_ser
  import inst_dy_pkg::*;
#(
  parameter int U_DLY    = 1,
  parameter int IDLE_GAP = 2
) (
  input  logic         clk_sys,
  input  logic         rst,
  input  logic [15:0]  cfg_ins_length,
  input  logic [127:0] dy_tx_data,
  input  logic         dy_tx_data_valid,
  input  logic         dy_byte_ready,
  output logic [7:0]   dy_byte_data,
  output logic         dy_byte_valid,
  output logic         dy_byte_sof,
  output logic         dy_byte_eof,
  output logic         dy_tx_busy,
  output logic         dy_tx_drop,
  output logic [15:0]  dy_frame_cnt
);

`ifdef DY_TX_CHECKSUM_EN
  localparam logic CSUM_EN = 1'b1;
`else
  localparam logic CSUM_EN = 1'b0;
`endif

  // Where a finished frame goes: straight back to IDLE when no gap is
  // requested, otherwise into GAP with the counter preloaded so that GAP
  // lasts exactly IDLE_GAP cycles.
  localparam dy_state_t           ST_AFTER   = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
  localparam logic                BUSY_AFTER = (IDLE_GAP != 0);
  localparam logic [DY_GAP_W-1:0] GAP_LOAD   = (IDLE_GAP == 0) ? '0 : DY_GAP_W'(IDLE_GAP - 1);

  dy_state_t               r_state;
  logic [DY_WORD_W-1:0]    r_word;       // bytes still to be presented, MSB first
  logic [DY_LEN_W-1:0]     r_len;
  logic [DY_IDX_W-1:0]     r_idx;        // index of the byte currently presented
  logic [DY_BYTE_W-1:0]    r_csum;       // sum of data bytes already handshaked
  logic [DY_GAP_W-1:0]     r_gap;
  logic [DY_BYTE_W-1:0]    r_byte_data;
  logic                    r_byte_valid;
  logic                    r_sof;
  logic                    r_eof;
  logic                    r_busy;
  logic                    r_drop;
  logic [15:0]             r_frame_cnt;

  logic [DY_LEN_W-1:0]     w_len_eff;
  logic                    w_hs;
  logic                    w_last_data;
  logic                    w_next_is_last;

  assign w_len_eff      = dy_len_eff(cfg_ins_length);
  assign w_hs           = r_byte_valid & dy_byte_ready;
  assign w_last_data    = (({1'b0, r_idx} + DY_LEN_W'(1)) == r_len);
  assign w_next_is_last = (({1'b0, r_idx} + DY_LEN_W'(2)) == r_len);

  // NOTE: every register here is updated with <= so all branches see the
  // pre-edge values; mixing in blocking writes would make later branches
  // read half-updated state.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      // NOTE: the word register is reset too: it is only 128 flops, not a
      // RAM, and a clean reset keeps stale instruct bytes off the bus.
      r_state      <= ST_IDLE;
      r_word       <= '0;
      r_len        <= '0;
      r_idx        <= '0;
      r_csum       <= '0;
      r_gap        <= '0;
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_sof        <= 1'b0;
      r_eof        <= 1'b0;
      r_busy       <= 1'b0;
      r_drop       <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (dy_tx_data_valid) begin
            if (w_len_eff != '0) begin
              // Byte0 goes out directly; the rest is kept pre-shifted.
              r_byte_data  <= dy_tx_data[127:120];
              r_word       <= dy_tx_data << DY_BYTE_W;
              r_len        <= w_len_eff;
              r_idx        <= '0;
              r_csum       <= '0;
              r_byte_valid <= 1'b1;
              r_sof        <= 1'b1;
              r_eof        <= (w_len_eff == DY_LEN_W'(1)) && !CSUM_EN;
              r_busy       <= 1'b1;
              r_state      <= ST_SEND;
            end else begin
              r_drop <= 1'b1;
            end
          end
        end

        ST_SEND: begin
          if (dy_tx_data_valid) r_drop <= 1'b1;
          if (w_hs) begin
            r_csum <= r_csum + r_byte_data;
            if (w_last_data) begin
              r_sof <= 1'b0;
              if (CSUM_EN) begin
                r_byte_data <= r_csum + r_byte_data;
                r_eof       <= 1'b1;
                r_state     <= ST_CSUM;
              end else begin
                r_byte_valid <= 1'b0;
                r_eof        <= 1'b0;
                r_frame_cnt  <= r_frame_cnt + 16'd1;
                r_gap        <= GAP_LOAD;
                r_busy       <= BUSY_AFTER;
                r_state      <= ST_AFTER;
              end
            end else begin
              r_byte_data <= r_word[DY_WORD_W-1 -: DY_BYTE_W];
              r_word      <= r_word << DY_BYTE_W;
              r_idx       <= r_idx + DY_IDX_W'(1);
              r_sof       <= 1'b0;
              r_eof       <= w_next_is_last && !CSUM_EN;
            end
          end
        end

        ST_CSUM: begin
          if (dy_tx_data_valid) r_drop <= 1'b1;
          if (w_hs) begin
            r_byte_valid <= 1'b0;
            r_eof        <= 1'b0;
            r_frame_cnt  <= r_frame_cnt + 16'd1;
            r_gap        <= GAP_LOAD;
            r_busy       <= BUSY_AFTER;
            r_state      <= ST_AFTER;
          end
        end

        ST_GAP: begin
          if (dy_tx_data_valid) r_drop <= 1'b1;
          if (r_gap == '0) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap - DY_GAP_W'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dy_byte_data  = r_byte_data;
  assign dy_byte_valid = r_byte_valid;
  assign dy_byte_sof   = r_sof;
  assign dy_byte_eof   = r_eof;
  assign dy_tx_busy    = r_busy;
  assign dy_tx_drop    = r_drop;
  assign dy_frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_inst_dy_byte_ser.sv
// -----------------------------------------------------------------------------
// tb_inst_dy_byte_ser
// Self-checking bench for inst_dy_byte_ser. A behavioural model holds the
// queue of bytes the sink should still receive plus the remaining idle gap;
// every cycle the DUT outputs are compared with the head of that queue and
// the model's busy/drop/count expectations. Honours DY_TX_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_inst_dy_byte_ser;

  localparam int IDLE_GAP = 2;

`ifdef DY_TX_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic         clk_sys = 1'b0;
  logic         rst;
  logic [15:0]  cfg_ins_length;
  logic [127:0] dy_tx_data;
  logic         dy_tx_data_valid;
  logic         dy_byte_ready;
  logic [7:0]   dy_byte_data;
  logic         dy_byte_valid;
  logic         dy_byte_sof;
  logic         dy_byte_eof;
  logic         dy_tx_busy;
  logic         dy_tx_drop;
  logic [15:0]  dy_frame_cnt;

  inst_dy_byte_ser #(.U_DLY(1), .IDLE_GAP(IDLE_GAP)) dut (
    .clk_sys          (clk_sys),
    .rst              (rst),
    .cfg_ins_length   (cfg_ins_length),
    .dy_tx_data       (dy_tx_data),
    .dy_tx_data_valid (dy_tx_data_valid),
    .dy_byte_ready    (dy_byte_ready),
    .dy_byte_data     (dy_byte_data),
    .dy_byte_valid    (dy_byte_valid),
    .dy_byte_sof      (dy_byte_sof),
    .dy_byte_eof      (dy_byte_eof),
    .dy_tx_busy       (dy_tx_busy),
    .dy_tx_drop       (dy_tx_drop),
    .dy_frame_cnt     (dy_frame_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } exp_byte_t;

  exp_byte_t   m_q[$];
  int          m_gap;
  logic        m_drop;
  logic [15:0] m_cnt;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_gap  = 0;
    m_drop = 1'b0;
    m_cnt  = '0;
  endtask

  // Queue up the bytes a frame should produce on the sink side.
  task automatic model_push_frame(input logic [15:0] len, input logic [127:0] word);
    int         n;
    logic [7:0] sum;
    logic [7:0] b;
    exp_byte_t  e;
    n   = (len > 16) ? 16 : int'(len);
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      b     = word[127 - 8*i -: 8];
      sum   = sum + b;
      e.d   = b;
      e.sof = (i == 0);
      e.eof = (i == n - 1) && !CK;
      m_q.push_back(e);
    end
    if (CK) begin
      e.d   = sum;
      e.sof = 1'b0;
      e.eof = 1'b1;
      m_q.push_back(e);
    end
  endtask

  // One clock cycle: compare outputs, drive inputs, advance the model across
  // the coming rising edge.
  task automatic step(input logic stb, input logic [15:0] len,
                      input logic [127:0] word, input logic rdy);
    logic idle_now;
    logic hs;
    exp_byte_t e;
    @(negedge clk_sys);
    idle_now = (m_q.size() == 0) && (m_gap == 0);
    check("valid", dy_byte_valid, m_q.size() != 0);
    if (m_q.size() != 0 && dy_byte_valid) begin
      check("data", dy_byte_data, m_q[0].d);
      check("sof",  dy_byte_sof,  m_q[0].sof);
      check("eof",  dy_byte_eof,  m_q[0].eof);
    end
    check("busy", dy_tx_busy, !idle_now);
    check("drop", dy_tx_drop, m_drop);
    check("cnt",  dy_frame_cnt, m_cnt);

    dy_tx_data_valid = stb;
    cfg_ins_length   = len;
    dy_tx_data       = word;
    dy_byte_ready    = rdy;

    hs     = (m_q.size() != 0) && rdy;
    m_drop = stb && (!idle_now || len == 16'd0);
    if (hs) begin
      e = m_q.pop_front();
      if (e.eof) m_cnt = m_cnt + 16'd1;
      if (m_q.size() == 0) m_gap = IDLE_GAP;
    end else if (m_q.size() == 0 && m_gap > 0) begin
      m_gap--;
    end
    if (stb && idle_now && len != 16'd0) model_push_frame(len, word);
  endtask

  task automatic idle_steps(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 16'd0, 128'd0, rdy);
  endtask

  function automatic logic [127:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst              = 1'b1;
    cfg_ins_length   = '0;
    dy_tx_data       = '0;
    dy_tx_data_valid = 1'b0;
    dy_byte_ready    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_sys);
    rst = 1'b0;

    // Reset state
    idle_steps(2, 1'b1);

    // 1: len 4, ready high
    step(1'b1, 16'd4, 128'h0102030405060708090A0B0C0D0E0F10, 1'b1);
    idle_steps(8, 1'b1);

    // 2: len 16, ready toggling
    step(1'b1, 16'd16, rand_word(), 1'b1);
    for (int i = 0; i < 40; i++) step(1'b0, 16'd0, 128'd0, logic'(i % 2));
    idle_steps(4, 1'b1);

    // 3: length 0 is dropped, length 40 clips to 16
    step(1'b1, 16'd0, rand_word(), 1'b1);
    idle_steps(2, 1'b1);
    step(1'b1, 16'd40, rand_word(), 1'b1);
    idle_steps(22, 1'b1);

    // 4: strobe held every cycle -> drops during SEND/GAP, accepted exactly
    //    in the cycle busy falls
    step(1'b1, 16'd5, rand_word(), 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 16'd3, rand_word(), 1'b1);
    idle_steps(8, 1'b1);

    // 5: async reset in the middle of an 8-byte frame
    step(1'b1, 16'd8, rand_word(), 1'b1);
    idle_steps(3, 1'b1);
    #3;
    dy_tx_data_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_valid", dy_byte_valid, 1'b0);
    check("rst_data",  dy_byte_data,  8'h00);
    check("rst_sof",   dy_byte_sof,   1'b0);
    check("rst_eof",   dy_byte_eof,   1'b0);
    check("rst_busy",  dy_tx_busy,    1'b0);
    check("rst_drop",  dy_tx_drop,    1'b0);
    check("rst_cnt",   dy_frame_cnt,  16'h0000);
    model_reset();
    @(negedge clk_sys);
    rst = 1'b0;
    step(1'b1, 16'd6, rand_word(), 1'b1);
    idle_steps(10, 1'b1);

    // 6: checksum frame FF,01,02
    step(1'b1, 16'd3, 128'hFF0102AABBCCDDEEFF00112233445566, 1'b1);
    idle_steps(8, 1'b0);
    idle_steps(8, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] len;
      len = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(17, 300))
                                        : 16'($urandom_range(0, 16));
      step(logic'($urandom_range(0, 5) == 0), len, rand_word(),
           logic'($urandom_range(0, 3) != 0));
    end

    // Drain and confirm the block settles idle
    idle_steps(40, 1'b1);
    @(negedge clk_sys);
    check("end_busy",  dy_tx_busy,    1'b0);
    check("end_valid", dy_byte_valid, 1'b0);
    check("end_cnt",   dy_frame_cnt,  m_cnt);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
